// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, NOP word,
// reset vector and next-PC select codes.
package if_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DROP  = 2'd2,
    S_HOLD  = 2'd3
  } if_state_t;

  localparam logic [31:0] NOP       = 32'h0000_0000;
  localparam logic [31:0] RESET_VEC = 32'h0000_0000;

  localparam logic [1:0] PCSRC_BR  = 2'b10;
  localparam logic [1:0] PCSRC_JMP = 2'b11;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats hold, hold beats load; a load with no
// word available inserts a bubble.
module if_id_reg
  import if_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        hold,
  input  logic        load_valid,
  input  logic [31:0] load_inst,
  input  logic [31:0] load_pc4,
  output logic [31:0] inst,
  output logic [31:0] pc4,
  output logic        valid
);

  logic [31:0] inst_reg;
  logic [31:0] pc4_reg;
  logic        valid_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_reg  <= NOP;
      pc4_reg   <= RESET_VEC;
      valid_reg <= 1'b0;
    end else if (flush) begin
      inst_reg  <= NOP;
      pc4_reg   <= RESET_VEC;
      valid_reg <= 1'b0;
    end else if (!hold) begin
      if (load_valid) begin
        inst_reg  <= load_inst;
        pc4_reg   <= load_pc4;
        valid_reg <= 1'b1;
      end else begin
        inst_reg  <= NOP;
        pc4_reg   <= RESET_VEC;
        valid_reg <= 1'b0;
      end
    end
  end

  assign inst  = inst_reg;
  assign pc4   = pc4_reg;
  assign valid = valid_reg;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage with request/ready memory port and IF/ID register.
// Optional performance counters Nfetch/Nbubble when IF_PERF_CNT_EN is defined.
module if_stage
  import if_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic        STALL,
  input  logic        Condep,
  input  logic [1:0]  Pcsrc,
  input  logic [31:0] Bpc,
  input  logic [31:0] Jpc,
  output logic        Ireq,
  output logic [31:0] Iaddr,
  input  logic        Irdy,
  input  logic [31:0] Idata,
  output logic [31:0] Dinst,
  output logic [31:0] Dpc4,
  output logic        Dvalid,
  output logic [31:0] Pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] Nfetch,
  output logic [31:0] Nbubble
`endif
);

  if_state_t   state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] stale_reg;
  logic [31:0] buf_inst_reg, buf_pc4_reg;

  logic        xfer, redirect, fetch_done, take, load_valid;
  logic [31:0] target, pc_plus4, load_inst, load_pc4;

  assign xfer       = Ireq & Irdy;
  assign redirect   = STALL & ((Pcsrc == PCSRC_BR) | (Pcsrc == PCSRC_JMP));
  assign target     = (Pcsrc == PCSRC_JMP) ? Jpc : Bpc;
  assign pc_plus4   = pc_reg + 32'd4;
  assign fetch_done = (state_reg == S_FETCH) & xfer;
  // A completed word is kept only when neither a redirect nor a flush kills it.
  assign take       = fetch_done & ~redirect & Condep;
  assign load_valid = (fetch_done & ~redirect) | (state_reg == S_HOLD);
  assign load_inst  = (state_reg == S_HOLD) ? buf_inst_reg : Idata;
  assign load_pc4   = (state_reg == S_HOLD) ? buf_pc4_reg  : pc_plus4;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE:  state_next = S_FETCH;
      S_FETCH: begin
        if (redirect && !xfer)  state_next = S_DROP;
        else if (take && !STALL) state_next = S_HOLD;
      end
      S_DROP:  if (xfer) state_next = S_FETCH;
      S_HOLD:  if (!Condep || STALL) state_next = S_FETCH;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    Ireq  = (state_reg == S_FETCH) || (state_reg == S_DROP);
    Iaddr = (state_reg == S_DROP) ? stale_reg : pc_reg;
  end

  always_comb begin
    pc_next = pc_reg;
    if (redirect)  pc_next = target;
    else if (take) pc_next = pc_plus4;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      pc_reg       <= RESET_VEC;
      stale_reg    <= RESET_VEC;
      buf_inst_reg <= NOP;
      buf_pc4_reg  <= RESET_VEC;
    end else begin
      pc_reg <= pc_next;
      // The in-flight request must finish at its original address after a redirect.
      if ((state_reg == S_FETCH) && redirect && !xfer)
        stale_reg <= pc_reg;
      if (take && !STALL) begin
        buf_inst_reg <= Idata;
        buf_pc4_reg  <= pc_plus4;
      end else if ((state_reg == S_HOLD) && !Condep) begin
        buf_inst_reg <= NOP;
        buf_pc4_reg  <= RESET_VEC;
      end
    end
  end

  if_id_reg u_if_id (
    .clk        (Clk),
    .rst        (Rst),
    .flush      (~Condep),
    .hold       (~STALL),
    .load_valid (load_valid),
    .load_inst  (load_inst),
    .load_pc4   (load_pc4),
    .inst       (Dinst),
    .pc4        (Dpc4),
    .valid      (Dvalid)
  );

  assign Pc = pc_reg;

`ifdef IF_PERF_CNT_EN
  logic [31:0] nfetch_reg, nbubble_reg;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      nfetch_reg  <= 32'd0;
      nbubble_reg <= 32'd0;
    end else begin
      if (take) nfetch_reg <= nfetch_reg + 32'd1;
      if (!Condep || (STALL && !load_valid)) nbubble_reg <= nbubble_reg + 32'd1;
    end
  end

  assign Nfetch  = nfetch_reg;
  assign Nbubble = nbubble_reg;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage: a scoreboard queue holds the words expected
// to enter IF/ID; each accepting cycle pops one and compares.
module tb_if_stage;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        STALL, Condep;
  logic [1:0]  Pcsrc;
  logic [31:0] Bpc, Jpc;
  logic        Ireq;
  logic [31:0] Iaddr;
  logic        Irdy;
  logic [31:0] Idata;
  logic [31:0] Dinst, Dpc4;
  logic        Dvalid;
  logic [31:0] Pc;
`ifdef IF_PERF_CNT_EN
  logic [31:0] Nfetch, Nbubble;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
  } exp_t;
  exp_t exp_q[$];

  if_stage dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .STALL  (STALL),
    .Condep (Condep),
    .Pcsrc  (Pcsrc),
    .Bpc    (Bpc),
    .Jpc    (Jpc),
    .Ireq   (Ireq),
    .Iaddr  (Iaddr),
    .Irdy   (Irdy),
    .Idata  (Idata),
    .Dinst  (Dinst),
    .Dpc4   (Dpc4),
    .Dvalid (Dvalid),
    .Pc     (Pc)
`ifdef IF_PERF_CNT_EN
    ,
    .Nfetch (Nfetch),
    .Nbubble(Nbubble)
`endif
  );

  always #5 Clk = ~Clk;

  // Instruction memory model: the word stored at an address encodes it.
  function automatic logic [31:0] word(input logic [31:0] addr);
    return 32'hC000_0000 | addr;
  endfunction

  assign Idata = Irdy ? word(Iaddr) : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] addr);
    exp_t e;
    e.inst = word(addr);
    e.pc4  = addr + 32'd4;
    exp_q.push_back(e);
  endtask

  // Advance one cycle; if IF/ID was allowed to load and now holds a word, score it.
  task automatic tick();
    logic acc;
    exp_t e;
    acc = STALL & Condep;
    @(posedge Clk);
    #1;
    if (acc && Dvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_word", Dpc4, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("sb_dinst", Dinst, e.inst);
        chk("sb_dpc4", Dpc4, e.pc4);
        $display("xfer: Dinst=%h Dpc4=%h", Dinst, Dpc4);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    Rst = 1'b1; STALL = 1'b1; Condep = 1'b1; Pcsrc = 2'b00;
    Bpc = 32'h0; Jpc = 32'h0; Irdy = 1'b0;
    tick(); tick();
    chk("rst_pc", Pc, 32'h0);
    chk("rst_ireq", {31'h0, Ireq}, 32'h0);
    chk("rst_dvalid", {31'h0, Dvalid}, 32'h0);
    chk("rst_dinst", Dinst, 32'h0);
    chk("rst_dpc4", Dpc4, 32'h0);

    // Zero-wait streaming from reset.
    Rst = 1'b0; Irdy = 1'b1;
    chk("idle_ireq", {31'h0, Ireq}, 32'h0);
    for (int i = 0; i < 4; i++) push(32'(i * 4));
    tick();
    chk("fetch_ireq", {31'h0, Ireq}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stream_dvalid", {31'h0, Dvalid}, 32'h1);
    end
    chk("stream_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("stream_pc", Pc, 32'd16);

    // Jump back to 8 while a word completes: the word is discarded.
    Pcsrc = 2'b11; Jpc = 32'd8;
    tick();
    chk("jmp_pc", Pc, 32'd8);
    chk("jmp_dvalid", {31'h0, Dvalid}, 32'h0);

    // Memory stalls for three cycles at Pc=8.
    Pcsrc = 2'b00; Irdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wait_iaddr", Iaddr, 32'd8);
      chk("wait_ireq", {31'h0, Ireq}, 32'h1);
      chk("wait_dvalid", {31'h0, Dvalid}, 32'h0);
    end
    Irdy = 1'b1; push(32'd8);
    tick();
    chk("wait_sb_empty", 32'(exp_q.size()), 32'd0);

    // Branch back to 8, then jump to 0x40 while the fetch at 8 is outstanding.
    Pcsrc = 2'b10; Bpc = 32'd8;
    tick();
    chk("br_pc", Pc, 32'd8);
    Pcsrc = 2'b00; Irdy = 1'b0;
    tick();
    Pcsrc = 2'b11; Jpc = 32'h40;
    tick();
    chk("drop_pc", Pc, 32'h40);
    chk("drop_iaddr", Iaddr, 32'd8);
    chk("drop_ireq", {31'h0, Ireq}, 32'h1);
    Pcsrc = 2'b00;
    tick();
    chk("drop_iaddr_hold", Iaddr, 32'd8);
    Irdy = 1'b1;
    tick();
    chk("drop_discard_dvalid", {31'h0, Dvalid}, 32'h0);
    chk("drop_next_iaddr", Iaddr, 32'h40);
    push(32'h40);
    tick();
    chk("drop_sb_empty", 32'(exp_q.size()), 32'd0);

    // Transfer completes under load-use stall: word parks in HOLD.
    STALL = 1'b0;
    tick();
    chk("hold_ireq", {31'h0, Ireq}, 32'h0);
    chk("hold_pc", Pc, 32'h48);
    chk("hold_dpc4_kept", Dpc4, 32'h44);
    tick();
    chk("hold_ireq2", {31'h0, Ireq}, 32'h0);
    STALL = 1'b1; push(32'h44); push(32'h48);
    tick();
    chk("hold_release_iaddr", Iaddr, 32'h48);
    tick();
    chk("hold_sb_empty", 32'(exp_q.size()), 32'd0);

    // Flush together with stall: bubble, no redirect, Pc stays.
    Condep = 1'b0; STALL = 1'b0; Pcsrc = 2'b11; Jpc = 32'h100;
    tick();
    chk("flush_dinst", Dinst, 32'h0);
    chk("flush_dvalid", {31'h0, Dvalid}, 32'h0);
    chk("flush_pc", Pc, 32'h4C);
    Condep = 1'b1; STALL = 1'b1; Pcsrc = 2'b00; push(32'h4C);
    tick();

    // PC wraps from the top of the address space.
    Pcsrc = 2'b11; Jpc = 32'hFFFF_FFFC;
    tick();
    Pcsrc = 2'b00; push(32'hFFFF_FFFC);
    tick();
    chk("wrap_pc", Pc, 32'h0);
    chk("wrap_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset pulse while waiting at 0x20.
    Pcsrc = 2'b11; Jpc = 32'h20;
    tick();
    Pcsrc = 2'b00; Irdy = 1'b0;
    tick();
    chk("prerst_iaddr", Iaddr, 32'h20);
    Rst = 1'b1;
    #2;
    chk("midrst_pc", Pc, 32'h0);
    chk("midrst_ireq", {31'h0, Ireq}, 32'h0);
    chk("midrst_dvalid", {31'h0, Dvalid}, 32'h0);
    #2;
    Rst = 1'b0; Irdy = 1'b1;
    chk("postrst_ireq", {31'h0, Ireq}, 32'h0);
    tick();
    chk("postrst_pc", Pc, 32'h0);
    chk("postrst_dvalid", {31'h0, Dvalid}, 32'h0);
    push(32'h0);
    tick();
    chk("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
